// File: rtl/segment_transition_ctl_pkg.sv
// Shared types for the segment transition controller: transition modes and FSM states.
package segment_transition_ctl_pkg;

  localparam int unsigned NumSegment = 2;

  typedef enum logic [7:0] {
    TransitionModeSyncIdx = 8'h00,
    TransitionModeSysTime = 8'h01,
    TransitionModeGpio    = 8'h02
  } transition_mode_t;

  typedef enum logic [1:0] {
    StRun,
    StWaitSync,
    StWaitTime,
    StWaitGpio
  } segment_transition_state_t;

endpackage

// File: rtl/segment_transition_ctl_gpio_edge_detect.sv
// Per-pin rising-edge detector against a registered copy of the inputs.
module gpio_edge_detect #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] gpio_i,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] gpio_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_q <= '0;
    end else begin
      gpio_q <= gpio_i;
    end
  end

  assign rise_o = gpio_i & ~gpio_q;

endmodule

// File: rtl/segment_transition_ctl.sv
// Holds a requested read segment until its transition condition fires, then swaps it in
// and tracks loop repetitions of the playing segment.
module segment_transition_ctl
  import segment_transition_ctl_pkg::*;
#(
  parameter int unsigned SysTimeWidth = 56,
  parameter int unsigned RepWidth     = 16,
  parameter int unsigned GpioWidth    = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    UPDATE,
  input  logic                    REQ_SEGMENT,
  input  logic [7:0]              TRANSITION_MODE,
  input  logic [63:0]             TRANSITION_VALUE,
  input  logic [RepWidth-1:0]     REP0,
  input  logic [RepWidth-1:0]     REP1,
  input  logic                    IDX_WRAP,
  input  logic [SysTimeWidth-1:0] SYS_TIME,
  input  logic [GpioWidth-1:0]    GPIO_IN,
  output logic                    SEGMENT,
  output logic                    SWITCHED,
  output logic                    PENDING,
  output logic                    STOP,
  output logic                    ERR_MODE
);

  localparam int unsigned GpioIdxW = (GpioWidth > 1) ? $clog2(GpioWidth) : 1;

  segment_transition_state_t state_q, state_d;
  logic                segment_q, segment_d;
  logic                req_seg_q, req_seg_d;
  logic [63:0]         value_q, value_d;
  logic [RepWidth-1:0] rep_pend_q, rep_pend_d;
  logic [RepWidth-1:0] rep_act_q, rep_act_d;
  logic [RepWidth-1:0] cnt_q, cnt_d;
  logic                stop_q, stop_d;
  logic                switched_q, switched_d;
  logic                pending_q, pending_d;
  logic                err_q, err_d;
  logic                do_switch;
  logic [GpioWidth-1:0] gpio_rise;
  logic                unused_value_hi;

  assign unused_value_hi = ^value_q[63:SysTimeWidth];

  gpio_edge_detect #(
    .Width (GpioWidth)
  ) u_gpio_edge (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .gpio_i (GPIO_IN),
    .rise_o (gpio_rise)
  );

  always_comb begin
    state_d    = state_q;
    segment_d  = segment_q;
    req_seg_d  = req_seg_q;
    value_d    = value_q;
    rep_pend_d = rep_pend_q;
    rep_act_d  = rep_act_q;
    cnt_d      = cnt_q;
    stop_d     = stop_q;
    switched_d = 1'b0;
    err_d      = 1'b0;
    do_switch  = 1'b0;

    unique case (state_q)
      StWaitSync: do_switch = IDX_WRAP;
      StWaitTime: do_switch = (SYS_TIME >= value_q[SysTimeWidth-1:0]);
      StWaitGpio: do_switch = gpio_rise[value_q[GpioIdxW-1:0]];
      default:    do_switch = 1'b0;
    endcase

    // Counter saturates at the repetition limit; all-ones means loop forever.
    if (IDX_WRAP) begin
      if (cnt_q == rep_act_q) begin
        if (rep_act_q != '1) begin
          stop_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (UPDATE) begin
      req_seg_d  = REQ_SEGMENT;
      value_d    = TRANSITION_VALUE;
      rep_pend_d = REQ_SEGMENT ? REP1 : REP0;
      case (TRANSITION_MODE)
        TransitionModeSyncIdx: state_d = StWaitSync;
        TransitionModeSysTime: state_d = StWaitTime;
        TransitionModeGpio:    state_d = StWaitGpio;
        default: begin
          state_d = StRun;
          err_d   = 1'b1;
        end
      endcase
    end else if (do_switch) begin
      // Switch beats a same-cycle STOP-causing wrap.
      segment_d  = req_seg_q;
      switched_d = 1'b1;
      cnt_d      = '0;
      stop_d     = 1'b0;
      rep_act_d  = rep_pend_q;
      state_d    = StRun;
    end

    pending_d = (state_d != StRun);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StRun;
      segment_q  <= 1'b0;
      req_seg_q  <= 1'b0;
      value_q    <= '0;
      rep_pend_q <= '1;
      rep_act_q  <= '1;
      cnt_q      <= '0;
      stop_q     <= 1'b0;
      switched_q <= 1'b0;
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      segment_q  <= segment_d;
      req_seg_q  <= req_seg_d;
      value_q    <= value_d;
      rep_pend_q <= rep_pend_d;
      rep_act_q  <= rep_act_d;
      cnt_q      <= cnt_d;
      stop_q     <= stop_d;
      switched_q <= switched_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
    end
  end

  assign SEGMENT  = segment_q;
  assign SWITCHED = switched_q;
  assign PENDING  = pending_q;
  assign STOP     = stop_q;
  assign ERR_MODE = err_q;

endmodule
